fpga_spi_arb: RTL and testbench

FPGA_SPI_ARB -- requirements
Module: fpga_spi_arb

---
 rtl/fpga_spi_arb.sv | 143 ++++++++++++++
 tb/tb_fpga_spi_arb.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_spi_arb.sv
// fpga_spi_arb: arbitrates one physical SPI bus between a CPU SPI master and a
// hardware 32-bit mode-0 transfer engine, with a guard gap between owners.
module fpga_spi_arb #(
    parameter int CLK_DIV   = 4,
    parameter int GUARD_CYC = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_spi_SCLK,
    input  logic        cpu_spi_MOSI,
    input  logic [1:0]  cpu_spi_SS_n,
    output logic        cpu_spi_MISO,
    input  logic        hw_req,
    input  logic        hw_ss_sel,
    input  logic [31:0] hw_wdata,
    output logic        hw_ack,
    output logic        hw_done,
    output logic [15:0] hw_rdata,
    output logic        spi_SCLK,
    output logic        spi_MOSI,
    output logic [1:0]  spi_SS_n,
    input  logic        spi_MISO,
    output logic        cpu_busy,
    output logic        cpu_collision,
    input  logic        cpu_collision_clr
);
    typedef enum logic [2:0] {IDLE, CPU_OWN, HW_LOAD, HW_SHIFT, HW_END, GUARD} state_t;
    state_t      state_q, state_d;
    logic [1:0]  ss_q, ss_d;
    logic        sclk_q, sclk_d, mosi_q, mosi_d, coll_q, coll_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  bcnt_q, bcnt_d;
    logic [30:0] tx_q, tx_d;
    logic [15:0] rx_q, rx_d, rdata_q, rdata_d;
    logic        cpu_sel, hw_own;
    assign cpu_sel = cpu_spi_SS_n != 2'b11;
    assign hw_own  = state_q inside {HW_LOAD, HW_SHIFT, HW_END};
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ss_q    <= 2'b11;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            coll_q  <= 1'b0;
            cnt_q   <= '0;
            bcnt_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ss_q    <= ss_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            coll_q  <= coll_d;
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
        end
    end
    always_comb begin
        state_d = state_q;
        ss_d    = ss_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        cnt_d   = cnt_q;
        bcnt_d  = bcnt_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        // a new collision outranks a clear in the same cycle
        coll_d  = (coll_q & ~cpu_collision_clr) | (hw_own & cpu_sel);
        case (state_q)
            IDLE: begin
                if (cpu_sel) begin
                    state_d = CPU_OWN;
                    ss_d    = cpu_spi_SS_n;
                    sclk_d  = cpu_spi_SCLK;
                    mosi_d  = cpu_spi_MOSI;
                end else if (hw_req) begin
                    state_d = HW_LOAD;
                    ss_d    = hw_ss_sel ? 2'b01 : 2'b10;
                    mosi_d  = hw_wdata[31];
                    tx_d    = hw_wdata[30:0];
                end
            end
            CPU_OWN: begin
                ss_d   = cpu_spi_SS_n;
                sclk_d = cpu_sel & cpu_spi_SCLK;
                mosi_d = cpu_sel & cpu_spi_MOSI;
                cnt_d  = '0;
                if (!cpu_sel) state_d = GUARD;
            end
            HW_LOAD: begin
                state_d = HW_SHIFT;
                cnt_d   = '0;
                bcnt_d  = '0;
            end
            HW_SHIFT: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'(CLK_DIV - 1)) begin
                    cnt_d  = '0;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        rx_d = {rx_q[14:0], spi_MISO};
                    end else if (bcnt_q == 5'd31) begin
                        state_d = HW_END;
                        mosi_d  = 1'b0;
                        rdata_d = rx_q;
                    end else begin
                        bcnt_d = bcnt_q + 5'd1;
                        tx_d   = {tx_q[29:0], 1'b0};
                        mosi_d = tx_q[30];
                    end
                end
            end
            HW_END: begin
                state_d = GUARD;
                ss_d    = 2'b11;
                cnt_d   = '0;
            end
            GUARD: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'(GUARD_CYC - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    assign spi_SS_n      = ss_q;
    assign spi_SCLK      = sclk_q;
    assign spi_MOSI      = mosi_q;
    assign hw_rdata      = rdata_q;
    assign hw_ack        = state_q == HW_LOAD;
    assign hw_done       = state_q == HW_END;
    assign cpu_collision = coll_q;
    assign cpu_spi_MISO  = state_q == CPU_OWN ? spi_MISO : 1'b1;
    assign cpu_busy      = hw_own | (state_q == IDLE & hw_req & ~cpu_sel & ~reset);
endmodule

// File: tb/tb_fpga_spi_arb.sv
// tb_fpga_spi_arb: directed checks of bus arbitration, hardware frames, collisions
// and reset behaviour against a mode-0 slave model.
module tb_fpga_spi_arb;
    localparam int CLK_DIV   = 4;
    localparam int GUARD_CYC = 2;
    logic        clk = 1'b0, reset = 1'b1;
    logic        cpu_spi_SCLK = 1'b0, cpu_spi_MOSI = 1'b0, cpu_spi_MISO;
    logic [1:0]  cpu_spi_SS_n = 2'b11;
    logic        hw_req = 1'b0, hw_ss_sel = 1'b0, hw_ack, hw_done;
    logic [31:0] hw_wdata = '0;
    logic [15:0] hw_rdata;
    logic        spi_SCLK, spi_MOSI, spi_MISO;
    logic [1:0]  spi_SS_n;
    logic        cpu_busy, cpu_collision, cpu_collision_clr = 1'b0;
    int          n_chk = 0, n_err = 0, cyc = 0, ack_cyc = 0;
    logic [31:0] slv_word = 32'h1234_A5C3;
    logic [31:0] slv_rx = '0;
    int          slv_idx = 0, slv_rises = 0;
    logic        miso_ovr = 1'b0, miso_val = 1'b0;
    logic [15:0] mosi_pat = 16'hB6C3;
    wire         ss_idle = &spi_SS_n;

    fpga_spi_arb #(.CLK_DIV(CLK_DIV), .GUARD_CYC(GUARD_CYC)) dut (
        .clk(clk), .reset(reset),
        .cpu_spi_SCLK(cpu_spi_SCLK), .cpu_spi_MOSI(cpu_spi_MOSI),
        .cpu_spi_SS_n(cpu_spi_SS_n), .cpu_spi_MISO(cpu_spi_MISO),
        .hw_req(hw_req), .hw_ss_sel(hw_ss_sel), .hw_wdata(hw_wdata),
        .hw_ack(hw_ack), .hw_done(hw_done), .hw_rdata(hw_rdata),
        .spi_SCLK(spi_SCLK), .spi_MOSI(spi_MOSI), .spi_SS_n(spi_SS_n),
        .spi_MISO(spi_MISO), .cpu_busy(cpu_busy), .cpu_collision(cpu_collision),
        .cpu_collision_clr(cpu_collision_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // mode-0 slave: presents word MSB first, next bit after each falling SCLK
    always @(negedge spi_SCLK or posedge ss_idle) slv_idx <= ss_idle ? 0 : slv_idx + 1;
    always @(posedge spi_SCLK or negedge ss_idle) begin
        if (!spi_SCLK) slv_rises <= 0;
        else begin
            slv_rx    <= {slv_rx[30:0], spi_MOSI};
            slv_rises <= slv_rises + 1;
        end
    end
    assign spi_MISO = miso_ovr ? miso_val : (slv_idx < 32 ? slv_word[31 - slv_idx] : 1'b0);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_xfer(input logic [31:0] w, input logic sel, input logic keep_req);
        int n = 0;
        hw_wdata  = w;
        hw_ss_sel = sel;
        hw_req    = 1'b1;
        do begin @(negedge clk); n++; end while (!hw_ack && n < 50);
        chk("ack", hw_ack, 1);
        chk("ss_load", spi_SS_n, sel ? 2'b01 : 2'b10);
        chk("mosi_b31", spi_MOSI, w[31]);
        chk("busy_load", cpu_busy, 1);
        ack_cyc = cyc;
        hw_req  = keep_req;
    endtask

    // hw_done lands 64*CLK_DIV+1 edges after hw_ack: 64*CLK_DIV+2 cycles inclusive
    task automatic finish_xfer(input logic [31:0] w, input logic [15:0] rd, input logic chk_hi);
        int n = 0, hi = 0;
        do begin @(negedge clk); n++; hi += int'(spi_SCLK); end while (!hw_done && n < 600);
        chk("done", hw_done, 1);
        chk("latency", cyc - ack_cyc, 64 * CLK_DIV + 1);
        chk("rdata", hw_rdata, rd);
        chk("slave_rx", slv_rx, w);
        chk("rises", slv_rises, 32);
        if (chk_hi) chk("sclk_hi", hi, 32 * CLK_DIV);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int n, cnt;
        logic ps, pm;
        repeat (2) @(negedge clk);
        chk("rst_ss", spi_SS_n, 2'b11);
        chk("rst_sclk", spi_SCLK, 0);
        chk("rst_mosi", spi_MOSI, 0);
        chk("rst_cmiso", cpu_spi_MISO, 1);
        chk("rst_ack", hw_ack, 0);
        chk("rst_done", hw_done, 0);
        chk("rst_rdata", hw_rdata, 0);
        chk("rst_busy", cpu_busy, 0);
        chk("rst_coll", cpu_collision, 0);
        reset = 1'b0;
        @(negedge clk);
        start_xfer(32'h0023_0000, 1'b1, 1'b0);
        finish_xfer(32'h0023_0000, 16'hA5C3, 1'b1);
        @(negedge clk);
        chk("ss_after", spi_SS_n, 2'b11);
        chk("busy_guard", cpu_busy, 0);
        repeat (3) @(negedge clk);
        chk("rdata_hold", hw_rdata, 16'hA5C3);
        // CPU passthrough: 8 SCLK pulses, outputs lag inputs by one cycle
        miso_ovr = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            cpu_spi_SS_n = 2'b10;
            cpu_spi_SCLK = (i % 2) == 1;
            cpu_spi_MOSI = mosi_pat[i % 16];
            miso_val     = ~miso_val;
            ps = cpu_spi_SCLK;
            pm = cpu_spi_MOSI;
            @(negedge clk);
            chk("cpu_ss", spi_SS_n, 2'b10);
            chk("cpu_sclk", spi_SCLK, ps);
            chk("cpu_mosi", spi_MOSI, pm);
            chk("cpu_miso", cpu_spi_MISO, miso_val);
            chk("cpu_noack", hw_ack, 0);
        end
        cpu_spi_SS_n = 2'b11;
        cpu_spi_SCLK = 1'b0;
        miso_val     = 1'b0;
        @(negedge clk);
        chk("cpu_rel_ss", spi_SS_n, 2'b11);
        chk("cpu_rel_sclk", spi_SCLK, 0);
        chk("miso_block", cpu_spi_MISO, 1);
        // request withdrawn during the guard gap is never acknowledged
        hw_req = 1'b1;
        @(negedge clk);
        hw_req = 1'b0;
        cnt = 0;
        repeat (10) begin @(negedge clk); cnt += int'(hw_ack); end
        chk("no_ack", cnt, 0);
        miso_ovr = 1'b0;
        // simultaneous CPU select and hw_req: CPU wins
        hw_wdata     = 32'hC0DE_0001;
        hw_ss_sel    = 1'b0;
        hw_req       = 1'b1;
        cpu_spi_SS_n = 2'b10;
        @(negedge clk);
        chk("tie_ack", hw_ack, 0);
        chk("tie_ss", spi_SS_n, 2'b10);
        chk("tie_busy", cpu_busy, 0);
        repeat (3) @(negedge clk);
        cpu_spi_SS_n = 2'b11;
        n = 0;
        do begin @(negedge clk); n++; end while (!hw_ack && n < 20);
        chk("grant_delay", n, GUARD_CYC + 2);
        ack_cyc = cyc;
        hw_req  = 1'b0;
        chk("tie_hw_ss", spi_SS_n, 2'b10);
        finish_xfer(32'hC0DE_0001, 16'hA5C3, 1'b1);
        // collision mid-frame, clear in the same cycle loses
        repeat (4) @(negedge clk);
        start_xfer(32'h8123_4567, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        cpu_spi_SS_n      = 2'b01;
        cpu_collision_clr = 1'b1;
        miso_ovr          = 1'b1;
        miso_val          = 1'b0;
        @(negedge clk);
        chk("coll_set_wins", cpu_collision, 1);
        cpu_collision_clr = 1'b0;
        @(negedge clk);
        chk("coll_miso", cpu_spi_MISO, 1);
        chk("coll_ss", spi_SS_n, 2'b10);
        chk("coll_busy", cpu_busy, 1);
        cpu_spi_SS_n = 2'b11;
        miso_ovr     = 1'b0;
        finish_xfer(32'h8123_4567, 16'hA5C3, 1'b0);
        @(negedge clk);
        chk("coll_sticky", cpu_collision, 1);
        cpu_collision_clr = 1'b1;
        @(negedge clk);
        cpu_collision_clr = 1'b0;
        chk("coll_clr", cpu_collision, 0);
        // reset mid-frame around bit 10
        repeat (4) @(negedge clk);
        start_xfer(32'h0055_AAAA, 1'b1, 1'b0);
        n = 0;
        while (slv_rises < 10 && n < 200) begin @(negedge clk); n++; end
        chk("bit10", slv_rises, 10);
        hw_req = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("arst_ss", spi_SS_n, 2'b11);
        chk("arst_sclk", spi_SCLK, 0);
        chk("arst_done", hw_done, 0);
        chk("arst_rdata", hw_rdata, 0);
        chk("arst_busy", cpu_busy, 0);
        chk("arst_cmiso", cpu_spi_MISO, 1);
        @(negedge clk);
        hw_req = 1'b0;
        reset  = 1'b0;
        cnt = 0;
        repeat (300) begin @(negedge clk); cnt += int'(hw_done); end
        chk("no_done", cnt, 0);
        start_xfer(32'h0023_0000, 1'b1, 1'b0);
        finish_xfer(32'h0023_0000, 16'hA5C3, 1'b1);
        // back-to-back frames with hw_req held high
        repeat (4) @(negedge clk);
        start_xfer(32'hAAAA_5555, 1'b0, 1'b1);
        hw_wdata = 32'h1357_9BDF;
        finish_xfer(32'hAAAA_5555, 16'hA5C3, 1'b1);
        n = 0;
        cnt = 0;
        do begin
            @(negedge clk);
            n++;
            if (spi_SS_n == 2'b11) cnt++;
        end while (spi_SS_n == 2'b11 && n < 20);
        chk("b2b_gap", cnt, GUARD_CYC + 1);
        chk("b2b_ack2", hw_ack, 1);
        ack_cyc = cyc;
        hw_req  = 1'b0;
        finish_xfer(32'h1357_9BDF, 16'hA5C3, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
